word_narrower: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/byte_msb_detect.sv | 33 +++
 rtl/word_narrower.sv | 133 +++++++++++++
 tb/tb_word_narrower.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-path word narrower.
// Holds the FSM state encoding, default widths and beat-count helpers.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int WORD_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;

    function automatic int nbytes(input int word_w, input int byte_w);
        return word_w / byte_w;
    endfunction

    // A single-beat word still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_msb_detect.sv
// Priority encoder: index of the highest nonzero byte of a word (0 if zero).
// Ports: word_i (word to scan), k_o (byte index). Built only with
// WORD_NARROWER_ZERO_SUPPRESS_EN defined.
`ifdef WORD_NARROWER_ZERO_SUPPRESS_EN
module byte_msb_detect
    import uart_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int KW     = 2
) (
    input  logic [WORD_W-1:0] word_i,
    output logic [KW-1:0]     k_o
);

    localparam int NBYTES = nbytes(WORD_W, BYTE_W);

    logic [NBYTES-1:0][BYTE_W-1:0] bytes;

    assign bytes = word_i;

    // Later (higher) hits overwrite earlier ones.
    always_comb begin
        k_o = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (|bytes[i]) begin
                k_o = KW'(i);
            end
        end
    end

endmodule
`endif

// File: rtl/word_narrower.sv
// Narrows a WORD_W word into BYTE_W beats for the UART TX byte interface.
// Ports: clock, reset (sync, active-high), enable (freeze when low);
//   in_valid/in_data/in_ready: word input handshake;
//   out_valid/out_data/out_last/out_ready: byte output handshake;
//   busy: a word is in flight.
// Optional: WORD_NARROWER_ZERO_SUPPRESS_EN drops leading zero bytes.
module word_narrower
    import uart_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam int NBYTES = nbytes(WORD_W, BYTE_W);
    localparam int CW     = cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] end_q, end_d;
    logic [CW-1:0] start_cnt;
    logic [CW-1:0] start_end;
    logic [CW-1:0] sel;
    logic          accept;
    logic          xfer;

    logic [NBYTES-1:0][BYTE_W-1:0] bytes;

    assign bytes = word_q;

`ifdef WORD_NARROWER_ZERO_SUPPRESS_EN
    logic [CW-1:0] msb_k;

    byte_msb_detect #(
        .WORD_W (WORD_W),
        .BYTE_W (BYTE_W),
        .KW     (CW)
    ) u_detect (
        .word_i (in_data),
        .k_o    (msb_k)
    );

    // MSB-first walks the counter up to LAST_IDX, so start
    // it where the selected byte index equals k.
    assign start_cnt = MSB_FIRST ? (LAST_IDX - msb_k) : '0;
    assign start_end = MSB_FIRST ? LAST_IDX : msb_k;
`else
    assign start_cnt = '0;
    assign start_end = LAST_IDX;
`endif

    assign sel    = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        end_d   = end_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    word_d  = in_data;
                    cnt_d   = start_cnt;
                    end_d   = start_end;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshakes are masked during reset so an in-flight
    // byte is never seen as transferred by either side.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = enable && !reset;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = enable && !reset;
                out_data  = bytes[sel];
                out_last  = out_valid && (cnt_q == end_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_word_narrower.sv
// Directed self-checking bench for word_narrower.
// Runs LSB-first and MSB-first instances side by side on shared inputs.
module tb_word_narrower;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        l_in_ready, l_valid, l_last, l_busy;
    logic [7:0]  l_data;
    logic        m_in_ready, m_valid, m_last, m_busy;
    logic [7:0]  m_data;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int x0;

    word_narrower #(
        .WORD_W    (32),
        .BYTE_W    (8),
        .MSB_FIRST (1'b0)
    ) u_lsb (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (l_in_ready),
        .out_valid (l_valid),
        .out_data  (l_data),
        .out_last  (l_last),
        .out_ready (out_ready),
        .busy      (l_busy)
    );

    word_narrower #(
        .WORD_W    (32),
        .BYTE_W    (8),
        .MSB_FIRST (1'b1)
    ) u_msb (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (m_in_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_ready (out_ready),
        .busy      (m_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (l_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag,
                        input logic [7:0] el,
                        input logic [7:0] em,
                        input logic lst);
        @(negedge clock);
        check({tag, "_vl"}, 32'(l_valid), 32'd1);
        check({tag, "_vm"}, 32'(m_valid), 32'd1);
        check({tag, "_dl"}, 32'(l_data), 32'(el));
        check({tag, "_dm"}, 32'(m_data), 32'(em));
        check({tag, "_ll"}, 32'(l_last), 32'(lst));
        check({tag, "_lm"}, 32'(m_last), 32'(lst));
        check({tag, "_rdy"}, 32'(l_in_ready), 32'd0);
        check({tag, "_busy"}, 32'(l_busy), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clock);
        check({tag, "_rl"}, 32'(l_in_ready), 32'd1);
        check({tag, "_rm"}, 32'(m_in_ready), 32'd1);
        check({tag, "_vl"}, 32'(l_valid), 32'd0);
        check({tag, "_busy"}, 32'(m_busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic start(input string tag, input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clock);
        check({tag, "_acc"}, 32'(l_in_ready & m_in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rdy", 32'(l_in_ready), 32'd0);
        check("rst_vld", 32'(l_valid | m_valid), 32'd0);
        check("rst_last", 32'(l_last | m_last), 32'd0);
        check("rst_busy", 32'(l_busy | m_busy), 32'd0);
        check("rst_data", 32'(l_data), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_chk("post_rst");

        // Basic word, both byte orders.
        start("w1", 32'hA1B2C3D4);
        beat("w1b0", 8'hD4, 8'hA1, 1'b0);
        beat("w1b1", 8'hC3, 8'hB2, 1'b0);
        beat("w1b2", 8'hB2, 8'hC3, 1'b0);
        beat("w1b3", 8'hA1, 8'hD4, 1'b1);
        idle_chk("w1_end");

        // Backpressure on the second byte.
        x0 = xfers;
        start("bp", 32'hA1B2C3D4);
        beat("bpb0", 8'hD4, 8'hA1, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold_v", 32'(l_valid), 32'd1);
            check("bp_hold_dl", 32'(l_data), 32'hC3);
            check("bp_hold_dm", 32'(m_data), 32'hB2);
            check("bp_hold_l", 32'(l_last), 32'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        beat("bpb1", 8'hC3, 8'hB2, 1'b0);
        beat("bpb2", 8'hB2, 8'hC3, 1'b0);
        beat("bpb3", 8'hA1, 8'hD4, 1'b1);
        idle_chk("bp_end");
        check("bp_xfers", 32'(xfers - x0), 32'd4);

        // Enable low mid-word, then reset mid-word.
        start("en", 32'hA1B2C3D4);
        beat("enb0", 8'hD4, 8'hA1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("en_off_v", 32'(l_valid | m_valid), 32'd0);
            check("en_off_d", 32'(l_data), 32'hC3);
            check("en_off_busy", 32'(l_busy), 32'd1);
            check("en_off_rdy", 32'(l_in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        enable = 1'b1;
        beat("enb1", 8'hC3, 8'hB2, 1'b0);
        reset = 1'b1;
        x0 = xfers;
        @(negedge clock);
        check("mrst_v", 32'(l_valid | m_valid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("mrst_v2", 32'(l_valid | m_valid), 32'd0);
        check("mrst_busy", 32'(l_busy | m_busy), 32'd0);
        check("mrst_rdy", 32'(l_in_ready & m_in_ready), 32'd1);
        check("mrst_data", 32'(l_data), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("mrst_quiet", 32'(l_valid | m_valid), 32'd0);
        end
        check("mrst_xfers", 32'(xfers - x0), 32'd0);
        @(posedge clock);
        #1;

        // in_valid held high across two words.
        x0 = xfers;
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        @(negedge clock);
        check("hv_acc1", 32'(l_in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_data = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            beat("hv_a", 8'h11, 8'h11, (i == 3));
        end
        @(negedge clock);
        check("hv_acc2", 32'(l_in_ready), 32'd1);
        check("hv_gap_v", 32'(l_valid), 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat("hv_b", 8'h22, 8'h22, (i == 3));
        end
        idle_chk("hv_end");
        check("hv_xfers", 32'(xfers - x0), 32'd8);

`ifdef WORD_NARROWER_ZERO_SUPPRESS_EN
        start("zs1", 32'h000000AB);
        beat("zs1b0", 8'hAB, 8'hAB, 1'b1);
        idle_chk("zs1_end");
        start("zs0", 32'h00000000);
        beat("zs0b0", 8'h00, 8'h00, 1'b1);
        idle_chk("zs0_end");
        start("zs3", 32'h0012AB00);
        beat("zs3b0", 8'h00, 8'h12, 1'b0);
        beat("zs3b1", 8'hAB, 8'hAB, 1'b0);
        beat("zs3b2", 8'h12, 8'h00, 1'b1);
        idle_chk("zs3_end");
`else
        start("nz1", 32'h000000AB);
        beat("nz1b0", 8'hAB, 8'h00, 1'b0);
        beat("nz1b1", 8'h00, 8'h00, 1'b0);
        beat("nz1b2", 8'h00, 8'h00, 1'b0);
        beat("nz1b3", 8'h00, 8'hAB, 1'b1);
        idle_chk("nz1_end");
        start("nz3", 32'h0012AB00);
        beat("nz3b0", 8'h00, 8'h00, 1'b0);
        beat("nz3b1", 8'hAB, 8'h12, 1'b0);
        beat("nz3b2", 8'h12, 8'hAB, 1'b0);
        beat("nz3b3", 8'h00, 8'h00, 1'b1);
        idle_chk("nz3_end");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
